rob_ins_scheduler: RTL and testbench
====================================

Name: rob_ins_scheduler

Overview:
Front-end controller for the op-centric reorder buffer.
- Allocates in-order sequence numbers (SNs) to dispatching ops, limited by the ROB depth.
- Shares the ROB's single insert port among p_nreq completing functional units using round-robin arbitration.
- Tracks in-flight occupancy using the ROB's dequeue completions.
- Sits between dispatch/functional units and the ROB insert and deq_front interfaces.

Parameters:
p_depth, `ROB_DEPTH, ROB entries; power of two, >= 2
p_ptrwidth, $clog2(p_depth), SN width
p_bitwidth, `ROB_BITWIDTH, payload width
p_nreq, 4, number of insert requesters; >= 2

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
alloc_en  in  1  dispatch requests an SN
alloc_cpl  out  1  SN granted this cycle
alloc_sn  out  p_ptrwidth  SN granted; valid when alloc_cpl=1
req_val  in  p_nreq  per-requester insert request
req_sn  in  p_nreq x p_ptrwidth  per-requester SN
req_data  in  p_nreq x p_bitwidth  per-requester payload
req_grant  out  p_nreq  one-hot; pulses in the cycle that requester's insert completes
rob_ins_en  out  1  drives the ROB ins_en
rob_ins_cpl  in  1  from the ROB ins_cpl
rob_ins_sn  out  p_ptrwidth  drives the ROB ins_sn_in
rob_ins_data  out  p_bitwidth  drives the ROB ins_data_in
rob_deq_cpl  in  1  from the ROB deq_front_cpl
inflight  out  p_ptrwidth+1  number of allocated, not-yet-dequeued SNs

Behaviour:
Reset (rst_n=0, asynchronous), all of the following take effect immediately:
- tail=0, inflight=0, state=IDLE, rr_ptr=0 (requester 0 has top priority).
- Insert holding registers cleared to 0.
- Outputs: alloc_cpl=0, alloc_sn=0, req_grant=0, rob_ins_en=0, rob_ins_sn=0, rob_ins_data=0, inflight=0.
- Reset mid-ISSUE abandons the held insert and no grant is issued.

Allocator:
- alloc_cpl = alloc_en && inflight < p_depth (combinational).
- alloc_sn = tail.
- On alloc_cpl, tail <= tail+1, wrapping modulo p_depth (p_depth-1 -> 0).
- inflight next value is inflight + alloc_cpl - rob_deq_cpl.
- Simultaneous alloc and deq leave inflight unchanged.
- When full (inflight == p_depth), alloc_cpl=0; alloc_cpl is reasserted the cycle after a deq.
- rob_deq_cpl while inflight==0 is ignored (no underflow) and flagged by a simulation assertion.

Insert FSM, states IDLE and ISSUE:
- IDLE: if any req_val, the arbiter selects the first set bit scanning from rr_ptr upward (with wrap). The scheduler latches that index, req_sn and req_data, then moves to ISSUE. If no req_val, it stays in IDLE.
- ISSUE: rob_ins_en=1, with rob_ins_sn and rob_ins_data driven from the held registers (stable until completion).
- On rob_ins_cpl: req_grant[idx]=1 in the same cycle, rr_ptr <= idx+1 mod p_nreq, next state IDLE.
- Without the optional feature, throughput is one insert per two cycles minimum.
- A requester holds req_val, req_sn and req_data until its req_grant and deasserts req_val in the following cycle. Requests that change while not held have no effect.
- rob_ins_cpl in IDLE is ignored.
- The SN window is not checked; the ROB owns correctness.

Optional Feature:
ROB_SCHED_BACK2BACK_EN
- Defined: in ISSUE with rob_ins_cpl=1, the arbiter also evaluates req_val in that cycle, masking the requester being granted. If another request is pending, the scheduler latches it and stays in ISSUE, giving one insert per cycle sustained. rr_ptr advances as normal.
- Undefined: the scheduler always returns to IDLE after a completion.

Decomposition:
- Package rob_sched_pkg holds:
  - state typedef enum {IDLE, ISSUE};
  - the default requester count constant ROB_SCHED_NREQ = 4.
- Sub-module rob_rr_arbiter: combinational round-robin. Inputs: req vector, rr_ptr, mask. Outputs: one-hot grant, encoded index, any.

Test Plan:
1. Allocate to full (p_depth=8): 8 consecutive alloc_en -> alloc_sn 0..7, alloc_cpl=1, inflight=8. Ninth request -> alloc_cpl=0. One rob_deq_cpl -> next cycle alloc_cpl=1, alloc_sn=0 (wrap).
2. Simultaneous alloc and deq at inflight=5 -> inflight stays 5, tail advances by 1. Deq at inflight=0 -> inflight stays 0 and the assertion fires.
3. Single requester: req_val[2]=1, sn=3, data=0xAB; ROB completes 2 cycles after rob_ins_en -> rob_ins_sn=3 and rob_ins_data=0xAB held stable; req_grant=0b0100 only in the cpl cycle.
4. Round-robin: req_val=0b1111 held, ROB cpl same cycle as en -> grant order 0,1,2,3,0; no requester granted twice before the others.
5. Reset asserted mid-ISSUE -> rob_ins_en=0 immediately, no grant; after release, requester 0 has priority.
6. With ROB_SCHED_BACK2BACK_EN: req_val=0b0011, cpl every cycle -> rob_ins_en continuously high, grants 0 then 1 in consecutive cycles. Without the macro: one cycle gap with rob_ins_en=0 between them.

Source files
------------

// File: rtl/rob_sched_pkg.sv
// Shared types and defaults for the ROB insert scheduler.
// ROB_DEPTH / ROB_BITWIDTH may be overridden on the command line.
`ifndef ROB_DEPTH
`define ROB_DEPTH 8
`endif
`ifndef ROB_BITWIDTH
`define ROB_BITWIDTH 8
`endif

package rob_sched_pkg;

  typedef enum logic {IDLE, ISSUE} sched_state_e;

  localparam int ROB_SCHED_NREQ     = 4;
  localparam int ROB_SCHED_DEPTH    = `ROB_DEPTH;
  localparam int ROB_SCHED_BITWIDTH = `ROB_BITWIDTH;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rob_ins_scheduler_if.sv
// Dispatch, functional-unit and ROB-facing signals of the insert scheduler.
// master = scheduler side, slave = dispatch/FU/ROB environment side.
interface rob_ins_scheduler_if
  import rob_sched_pkg::*;
#(
  parameter int p_depth    = ROB_SCHED_DEPTH,
  parameter int p_ptrwidth = $clog2(p_depth),
  parameter int p_bitwidth = ROB_SCHED_BITWIDTH,
  parameter int p_nreq     = ROB_SCHED_NREQ
) ();

  logic                                  alloc_en;
  logic                                  alloc_cpl;
  logic [p_ptrwidth-1:0]                 alloc_sn;
  logic [p_nreq-1:0]                     req_val;
  logic [p_nreq-1:0][p_ptrwidth-1:0]     req_sn;
  logic [p_nreq-1:0][p_bitwidth-1:0]     req_data;
  logic [p_nreq-1:0]                     req_grant;
  logic                                  rob_ins_en;
  logic                                  rob_ins_cpl;
  logic [p_ptrwidth-1:0]                 rob_ins_sn;
  logic [p_bitwidth-1:0]                 rob_ins_data;
  logic                                  rob_deq_cpl;
  logic [p_ptrwidth:0]                   inflight;

  modport master (
    input  alloc_en, req_val, req_sn, req_data, rob_ins_cpl, rob_deq_cpl,
    output alloc_cpl, alloc_sn, req_grant, rob_ins_en, rob_ins_sn, rob_ins_data, inflight
  );

  modport slave (
    output alloc_en, req_val, req_sn, req_data, rob_ins_cpl, rob_deq_cpl,
    input  alloc_cpl, alloc_sn, req_grant, rob_ins_en, rob_ins_sn, rob_ins_data, inflight
  );

endinterface

// File: rtl/rob_rr_arbiter.sv
// Combinational round-robin pick: first unmasked request at or after ptr_i, with wrap.
// Zero latency; no backpressure (pure function of inputs).
module rob_rr_arbiter #(
  parameter int p_nreq = 4
) (
  input  logic [p_nreq-1:0]         req_i,
  input  logic [$clog2(p_nreq)-1:0] ptr_i,
  input  logic [p_nreq-1:0]         mask_i,
  output logic [p_nreq-1:0]         grant_o,
  output logic [$clog2(p_nreq)-1:0] idx_o,
  output logic                      any_o
);

  localparam int IW = $clog2(p_nreq);

  int            jj;
  logic [IW-1:0] j;
  logic          found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    jj      = 0;
    j       = '0;
    for (int i = 0; i < p_nreq; i++) begin
      jj = int'(ptr_i) + i;
      if (jj >= p_nreq) jj = jj - p_nreq;
      j = IW'(jj);
      if (!found && req_i[j] && !mask_i[j]) begin
        found      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = j;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/rob_ins_scheduler.sv
// ROB front end: in-order SN allocation bounded by depth, round-robin share of the insert port.
// Optional ROB_SCHED_BACK2BACK_EN re-arbitrates on completion for one insert per cycle.
module rob_ins_scheduler
  import rob_sched_pkg::*;
#(
  parameter int p_depth    = ROB_SCHED_DEPTH,
  parameter int p_ptrwidth = $clog2(p_depth),
  parameter int p_bitwidth = ROB_SCHED_BITWIDTH,
  parameter int p_nreq     = ROB_SCHED_NREQ
) (
  input logic                 clk,
  input logic                 rst_n,
  rob_ins_scheduler_if.master bus
);

  localparam int IW = $clog2(p_nreq);

  // ---------------- allocator ----------------
  logic [p_ptrwidth-1:0] tail_q, tail_d;
  logic [p_ptrwidth:0]   inflight_q, inflight_d;
  logic                  alloc_ok, deq_ok;

  // rst_n gate keeps alloc_cpl low while reset is held, even with alloc_en high
  assign alloc_ok = rst_n && bus.alloc_en && (inflight_q < (p_ptrwidth+1)'(p_depth));
  assign deq_ok   = bus.rob_deq_cpl && (inflight_q != '0);

  always_comb begin
    tail_d     = alloc_ok ? tail_q + p_ptrwidth'(1) : tail_q;
    inflight_d = inflight_q + (p_ptrwidth+1)'(alloc_ok) - (p_ptrwidth+1)'(deq_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tail_q     <= '0;
      inflight_q <= '0;
    end else begin
      tail_q     <= tail_d;
      inflight_q <= inflight_d;
    end
  end

  assign bus.alloc_cpl = alloc_ok;
  assign bus.alloc_sn  = tail_q;
  assign bus.inflight  = inflight_q;

  // ---------------- insert scheduler ----------------
  sched_state_e            state_q;
  logic [IW-1:0]           rr_ptr_q, idx_q, idx_nxt, arb_ptr, arb_idx;
  logic [p_nreq-1:0]       grant_q, arb_mask, arb_grant;
  logic                    arb_any;
  logic [p_ptrwidth-1:0]   sn_q;
  logic [p_bitwidth-1:0]   data_q;

  assign idx_nxt = IW'(rr_next(int'(idx_q), p_nreq));

`ifdef ROB_SCHED_BACK2BACK_EN
  // During a completing ISSUE, arbitrate as if rr_ptr had already advanced past idx_q.
  assign arb_ptr  = (state_q == ISSUE) ? idx_nxt : rr_ptr_q;
  assign arb_mask = (state_q == ISSUE) ? grant_q : '0;
`else
  assign arb_ptr  = rr_ptr_q;
  assign arb_mask = '0;
`endif

  rob_rr_arbiter #(.p_nreq(p_nreq)) u_arb (
    .req_i   (bus.req_val),
    .ptr_i   (arb_ptr),
    .mask_i  (arb_mask),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .any_o   (arb_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      idx_q    <= '0;
      grant_q  <= '0;
      sn_q     <= '0;
      data_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arb_any) begin
            idx_q   <= arb_idx;
            grant_q <= arb_grant;
            sn_q    <= bus.req_sn[arb_idx];
            data_q  <= bus.req_data[arb_idx];
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.rob_ins_cpl) begin
            rr_ptr_q <= idx_nxt;
`ifdef ROB_SCHED_BACK2BACK_EN
            if (arb_any) begin
              idx_q   <= arb_idx;
              grant_q <= arb_grant;
              sn_q    <= bus.req_sn[arb_idx];
              data_q  <= bus.req_data[arb_idx];
            end else begin
              state_q <= IDLE;
            end
`else
            state_q <= IDLE;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rob_ins_en   = (state_q == ISSUE);
  assign bus.rob_ins_sn   = sn_q;
  assign bus.rob_ins_data = data_q;
  assign bus.req_grant    = (state_q == ISSUE && bus.rob_ins_cpl) ? grant_q : '0;

`ifndef SYNTHESIS
  deq_underflow_a: assert property (@(posedge clk) disable iff (!rst_n)
                                    !(bus.rob_deq_cpl && inflight_q == '0))
    else $warning("rob_deq_cpl with no SN in flight; ignored");
`endif

endmodule

// File: tb/tb_rob_ins_scheduler.sv
// Scoreboard bench for rob_ins_scheduler: random + directed stimulus against a transaction-level model.
module tb_rob_ins_scheduler;
  import rob_sched_pkg::*;

  localparam int D  = 8;
  localparam int PW = $clog2(D);
  localparam int W  = 8;
  localparam int N  = ROB_SCHED_NREQ;
`ifdef ROB_SCHED_BACK2BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  typedef struct {int idx; int sn; int data;} ins_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rob_ins_scheduler_if #(.p_depth(D), .p_bitwidth(W), .p_nreq(N)) bus ();

  rob_ins_scheduler #(.p_depth(D), .p_bitwidth(W), .p_nreq(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int   m_tail, m_infl, m_ptr;
  int   exp_alloc_q[$];
  int   exp_infl_q[$];
  ins_t ins_q[$];

  logic [N-1:0]  prev_req, prev_grant, last_grant;
  logic          prev_en, prev_cpl;
  logic [PW-1:0] prev_sn [N];
  logic [W-1:0]  prev_data [N];
  bit            mon_en;

  // stimulus knobs
  int           req_prob, lat_lo, lat_hi, rob_cnt;
  logic [N-1:0] req_mask;
  bit           rob_hold, fix_en;
  logic [PW-1:0] fix_sn;
  logic [W-1:0]  fix_data;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  task automatic knobs(input int prob, input logic [N-1:0] mask, input int lo, input int hi);
    req_prob = prob;
    req_mask = mask;
    lat_lo   = lo;
    lat_hi   = hi;
    rob_cnt  = lo;
  endtask

  task automatic model_reset();
    m_tail = 0; m_infl = 0; m_ptr = 0;
    exp_alloc_q.delete(); exp_infl_q.delete(); ins_q.delete();
    prev_req = '0; prev_grant = '0; last_grant = '0; prev_en = 1'b0; prev_cpl = 1'b0;
    for (int i = 0; i < N; i++) begin prev_sn[i] = '0; prev_data[i] = '0; end
  endtask

  // One clock of stimulus: requesters, ROB responder, allocator inputs + expectations.
  task automatic cyc(input bit a, input bit d);
    bit ok_a, ok_d;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      if (bus.req_val[i] && last_grant[i]) begin
        bus.req_val[i] = 1'b0;
      end else if (!bus.req_val[i] && req_mask[i] && $urandom_range(99, 0) < req_prob) begin
        bus.req_val[i]  = 1'b1;
        bus.req_sn[i]   = fix_en ? fix_sn   : PW'($urandom);
        bus.req_data[i] = fix_en ? fix_data : W'($urandom);
      end
    end
    if (bus.rob_ins_en && !rob_hold) begin
      if (rob_cnt <= 0) begin
        bus.rob_ins_cpl = 1'b1;
        rob_cnt = $urandom_range(lat_hi, lat_lo);
      end else begin
        bus.rob_ins_cpl = 1'b0;
        rob_cnt--;
      end
    end else begin
      bus.rob_ins_cpl = !bus.rob_ins_en && !rob_hold && ($urandom_range(9, 0) == 0);
    end
    bus.alloc_en    = a;
    bus.rob_deq_cpl = d;
    ok_a = a && (m_infl < D);
    ok_d = d && (m_infl > 0);
    if (ok_a) begin
      exp_alloc_q.push_back(m_tail);
      m_tail = (m_tail + 1) % D;
    end
    exp_infl_q.push_back(m_infl);
    m_infl = m_infl + int'(ok_a) - int'(ok_d);
  endtask

  // Monitor: pops expectations and compares at mid-cycle.
  always @(negedge clk) begin : mon
    logic [N-1:0] pend, exp_g;
    logic         start, exp_en;
    int           k;
    last_grant = bus.req_grant;
    if (mon_en && rst_n) begin
      if (exp_alloc_q.size() > 0) begin
        k = exp_alloc_q.pop_front();
        chk("alloc_cpl", bus.alloc_cpl, 1);
        chk("alloc_sn", bus.alloc_sn, k);
      end else begin
        chk("alloc_cpl_none", bus.alloc_cpl, 0);
      end
      if (exp_infl_q.size() > 0) chk("inflight", bus.inflight, exp_infl_q.pop_front());

      // a new insert is selected from requests pending in the previous cycle
      pend   = prev_req & ~prev_grant;
      start  = (pend != '0) && (!prev_en || (B2B && prev_cpl));
      exp_en = start || (prev_en && !prev_cpl);
      chk("rob_ins_en", bus.rob_ins_en, exp_en);
      if (start) begin
        k = rr_pick(pend, m_ptr);
        ins_q.push_back('{idx: k, sn: int'(prev_sn[k]), data: int'(prev_data[k])});
      end
      if (bus.rob_ins_en && ins_q.size() > 0) begin
        chk("rob_ins_sn", bus.rob_ins_sn, ins_q[0].sn);
        chk("rob_ins_data", bus.rob_ins_data, ins_q[0].data);
      end
      exp_g = '0;
      if (bus.rob_ins_en && bus.rob_ins_cpl && ins_q.size() > 0) begin
        exp_g[ins_q[0].idx] = 1'b1;
        m_ptr = (ins_q[0].idx + 1) % N;
        void'(ins_q.pop_front());
      end
      chk("req_grant", bus.req_grant, exp_g);

      prev_req   = bus.req_val;
      prev_grant = bus.req_grant;
      prev_en    = bus.rob_ins_en;
      prev_cpl   = bus.rob_ins_cpl;
      for (int i = 0; i < N; i++) begin
        prev_sn[i]   = bus.req_sn[i];
        prev_data[i] = bus.req_data[i];
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    mon_en = 1'b0;
    bus.alloc_en = 1'b1;
    bus.req_val = '0; bus.req_sn = '0; bus.req_data = '0;
    bus.rob_ins_cpl = 1'b0; bus.rob_deq_cpl = 1'b0;
    rob_hold = 1'b0; fix_en = 1'b0; fix_sn = '0; fix_data = '0;
    knobs(0, '0, 0, 0);
    model_reset();

    // reset state (alloc_en held high to show it is gated)
    #12;
    chk("rst_alloc_cpl", bus.alloc_cpl, 0);
    chk("rst_alloc_sn", bus.alloc_sn, 0);
    chk("rst_inflight", bus.inflight, 0);
    chk("rst_ins_en", bus.rob_ins_en, 0);
    chk("rst_grant", bus.req_grant, 0);
    bus.alloc_en = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    mon_en = 1'b1;

    // allocate to full, then one dequeue re-opens allocation with wrapped SN
    for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0);
    @(negedge clk);
    chk("full_no_alloc", bus.alloc_cpl, 0);
    chk("full_inflight", bus.inflight, D);
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    @(negedge clk);
    chk("wrap_alloc_cpl", bus.alloc_cpl, 1);
    chk("wrap_alloc_sn", bus.alloc_sn, 0);

    // simultaneous alloc + deq at 5, then deq at empty
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b0);
    @(negedge clk);
    chk("alloc_deq_infl", bus.inflight, 5);
    chk("alloc_deq_tail", bus.alloc_sn, 2);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    @(negedge clk);
    chk("deq_empty_infl", bus.inflight, 0);

    // single requester with fixed payload, ROB latency 2
    fix_en = 1'b1; fix_sn = PW'(3); fix_data = 8'hAB;
    knobs(100, 4'b0100, 2, 2);
    for (int t = 0; t < 10 && !bus.rob_ins_en; t++) cyc(1'b0, 1'b0);
    @(negedge clk);
    chk("t3_ins_en", bus.rob_ins_en, 1);
    chk("t3_sn", bus.rob_ins_sn, 3);
    chk("t3_data", bus.rob_ins_data, 8'hAB);
    chk("t3_no_early_grant", bus.req_grant, 0);
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0);
    fix_en = 1'b0;

    // all four requesting, zero-latency ROB: round-robin order
    knobs(100, 4'b1111, 0, 0);
    for (int i = 0; i < 24; i++) cyc(1'b0, 1'b0);

    // two requesters, completion every cycle: back-to-back vs gap
    knobs(100, 4'b0011, 0, 0);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0);

    // randomized mix
    knobs(60, 4'b1111, 0, 3);
    for (int i = 0; i < 1500; i++)
      cyc(1'($urandom_range(1, 0)), (m_infl > 0) && ($urandom_range(1, 0) == 1));

    // reset in the middle of an ISSUE
    knobs(100, 4'b0010, 0, 0);
    rob_hold = 1'b1;
    for (int t = 0; t < 20 && !bus.rob_ins_en; t++) cyc(1'b0, 1'b0);
    chk("pre_reset_issue", bus.rob_ins_en, 1);
    mon_en = 1'b0;
    bus.alloc_en = 1'b1;
    bus.rob_ins_cpl = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ins_en", bus.rob_ins_en, 0);
    chk("mid_rst_grant", bus.req_grant, 0);
    chk("mid_rst_sn", bus.rob_ins_sn, 0);
    chk("mid_rst_data", bus.rob_ins_data, 0);
    chk("mid_rst_alloc", bus.alloc_cpl, 0);
    chk("mid_rst_infl", bus.inflight, 0);
    bus.alloc_en = 1'b0; bus.rob_ins_cpl = 1'b0; bus.rob_deq_cpl = 1'b0; bus.req_val = '0;
    rob_hold = 1'b0;
    knobs(0, '0, 0, 0);
    @(posedge clk); #3;
    model_reset();
    rst_n = 1'b1;
    mon_en = 1'b1;
    knobs(100, 4'b1111, 0, 1);
    for (int t = 0; t < 20 && last_grant == '0; t++) cyc(1'b0, 1'b0);
    chk("post_reset_prio", last_grant, 4'b0001);

    knobs(50, 4'b1111, 0, 2);
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(1, 0)), (m_infl > 0) && ($urandom_range(2, 0) == 0));

    // drain
    knobs(0, 4'b1111, 0, 2);
    for (int i = 0; i < 40; i++) cyc(1'b0, 1'b0);
    @(negedge clk);
    chk("ins_drained", ins_q.size(), 0);
    chk("alloc_drained", exp_alloc_q.size(), 0);
    chk("req_drained", bus.req_val, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
